// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receiver, transmitter and baud generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    localparam int UART_SAMPLING_RATE = 16;
    localparam int UART_DATA_BITS     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer bringing the asynchronous rx line into the clk domain.
// Latency: 2 clk from d to q.
// Backpressure: none; the line is sampled every clk. Both flops reset to the idle level (1).
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, oversampled by baud_tick.
// Latency: rx_valid/frame_err pulse on the clk edge that samples mid stop bit (+2 clk synchronizer).
// Backpressure: none; rx_valid is a one-clk pulse with no ready, and baud_tick low freezes the FSM.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SAMPLING_RATE = UART_SAMPLING_RATE,
    parameter int DATA_BITS     = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(SAMPLING_RATE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLING_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLING_RATE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d;
    logic                 ferr_d;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
        end
    end

    // Next-state logic; everything holds unless a sample tick arrives, pulses default low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = rx_data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit in so short low glitches are dropped.
                    if (cnt_q == CNT_MID) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Return to IDLE at mid stop bit so a back-to-back start edge is not missed.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back frames, glitch, bad stop, reset abort, tick freeze.
// The tick runs every 4 clk (bit = 64 clk) so the whole run stays short.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick = 1'b0;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    logic       tick_en = 1'b0;
    int         div = 0;

    int         valid_cnt  = 0;
    int         ferr_cnt   = 0;
    int         both_cnt   = 0;
    int         wide_cnt   = 0;
    logic       valid_prev = 1'b0;
    logic       ferr_prev  = 1'b0;

    int         pass_cnt  = 0;
    int         total_cnt = 0;

    uart_rx #(.SAMPLING_RATE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Sample strobe, one clk wide every 4 clk; the divider freezes with the tick.
    always @(negedge clk) begin
        if (tick_en) begin
            baud_tick = (div == 3);
            div       = (div == 3) ? 0 : div + 1;
        end else begin
            baud_tick = 1'b0;
        end
    end

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (frame_err) ferr_cnt++;
        if (rx_valid && frame_err) both_cnt++;
        if (rx_valid && valid_prev) wide_cnt++;
        if (frame_err && ferr_prev) wide_cnt++;
        valid_prev = rx_valid;
        ferr_prev  = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one frame. stop_len is the stop-bit length in clk; pause_bit/abort_bit index the
    // line bit (0 = start, 1..8 = data, 9 = stop) at which ticks are frozen or reset is hit (-1 = none).
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                              input int pause_bit, input int abort_bit);
        logic [8:0] bits;
        int         snap;
        bits = {d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = (i == 9) ? stop_v : bits[i];
            if (i == abort_bit) begin
                repeat (20) @(negedge clk);
                rst = 1'b1;
                rx  = 1'b1;
                repeat (3) @(negedge clk);
                check("rst_valid", 32'(rx_valid), 32'd0);
                check("rst_ferr", 32'(frame_err), 32'd0);
                check("rst_data", 32'(rx_data), 32'd0);
                rst = 1'b0;
                return;
            end
            if (i == pause_bit) begin
                repeat (20) @(negedge clk);
                snap    = valid_cnt + ferr_cnt;
                tick_en = 1'b0;
                repeat (1000) @(negedge clk);
                check("pause_state", 32'(dut.state_q), 32'(DATA));
                check("pause_pulses", 32'(valid_cnt + ferr_cnt), 32'(snap));
                tick_en = 1'b1;
                repeat (BIT_CLK - 21) @(negedge clk);
            end else if (i == 9) begin
                repeat (stop_len - 1) @(negedge clk);
            end else begin
                repeat (BIT_CLK - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        int v0;
        int f0;

        rst     = 1'b1;
        rx      = 1'b1;
        tick_en = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));

        // Single good frame.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, BIT_CLK, -1, -1);
        check("a5_valid", 32'(valid_cnt - v0), 32'd1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Back-to-back frames with a single stop bit.
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, BIT_CLK, -1, -1);
        check("b2b0_valid", 32'(valid_cnt - v0), 32'd1);
        check("b2b0_data", 32'(rx_data), 32'h00);
        send_frame(8'hFF, 1'b1, BIT_CLK, -1, -1);
        check("b2b1_valid", 32'(valid_cnt - v0), 32'd2);
        check("b2b1_data", 32'(rx_data), 32'hFF);
        repeat (40) @(negedge clk);

        // Short low glitch: 4 ticks low, rejected at mid start bit.
        v0 = valid_cnt; f0 = ferr_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));
        check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Good 0x11, then 0x3C with a low stop bit; the low tail is short enough to be a rejected glitch.
        send_frame(8'h11, 1'b1, BIT_CLK, -1, -1);
        check("g11_data", 32'(rx_data), 32'h11);
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 48, -1, -1);
        repeat (100) @(negedge clk);
        check("bad_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("bad_valid", 32'(valid_cnt - v0), 32'd0);
        check("bad_data", 32'(rx_data), 32'h11);
        check("bad_state", 32'(dut.state_q), 32'(IDLE));

        // Reset in data bit 4 of 0x5A, then a clean 0x5A.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, BIT_CLK, -1, 5);
        repeat (40) @(negedge clk);
        send_frame(8'h5A, 1'b1, BIT_CLK, -1, -1);
        repeat (40) @(negedge clk);
        check("abort_valid", 32'(valid_cnt - v0), 32'd1);
        check("abort_data", 32'(rx_data), 32'h5A);
        check("abort_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Ticks frozen for 1000 clk inside data bit 3 of 0xC3.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hC3, 1'b1, BIT_CLK, 4, -1);
        repeat (40) @(negedge clk);
        check("pause_valid", 32'(valid_cnt - v0), 32'd1);
        check("pause_data", 32'(rx_data), 32'hC3);
        check("pause_ferr", 32'(ferr_cnt - f0), 32'd0);

        check("never_both", 32'(both_cnt), 32'd0);
        check("pulse_width", 32'(wide_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: SAMPLING_RATE, default 16, number of sample ticks per bit period; SHALL be even and >= 4.
REQ-002 Parameter: DATA_BITS, default 8, number of data bits per frame; SHALL be in the range 5 to 8.
REQ-003 Port: clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: baud_tick  input  1  one-clk-wide sample strobe at BAUD_RATE*SAMPLING_RATE, driven by uart_baud_gen.
REQ-006 Port: rx  input  1  asynchronous serial line; idles high.
REQ-007 Port: rx_data  output  DATA_BITS  last correctly received byte, LSB first on the line.
REQ-008 Port: rx_valid  output  1  one-clk pulse when rx_data has been updated.
REQ-009 Port: frame_err  output  1  one-clk pulse when the stop bit is sampled low.

Function
REQ-010 Frame format SHALL be 8N1-style: 1 start bit (low), DATA_BITS data bits sent LSB first, no parity, 1 stop bit (high).
REQ-011 rx SHALL pass through a 2-flop synchronizer, reset to 1, before any use; this adds 2 clk of latency.
REQ-012 Sample counter width SHALL be $clog2(SAMPLING_RATE); the counter and the FSM SHALL advance only on clk edges where baud_tick=1.
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-014 IDLE: on a tick with synced rx=0, go to START with counter=0.
REQ-015 START: on the tick where counter=SAMPLING_RATE/2-1 (mid start bit), the FSM SHALL go to DATA with counter=0 if rx=0, or back to IDLE if rx=1 (glitch reject); on other ticks the counter increments.
REQ-016 DATA: on the tick where counter=SAMPLING_RATE-1, rx SHALL be shifted into the MSB of the shift register (right shift), counter cleared and bit index incremented.
REQ-017 DATA: after DATA_BITS bits have been shifted in, the FSM SHALL go to STOP.
REQ-018 STOP: on the tick where counter=SAMPLING_RATE-1, if rx=1 the FSM SHALL load rx_data from the shift register and pulse rx_valid.
REQ-019 STOP: on that same tick, if rx=0 the FSM SHALL pulse frame_err, leave rx_data unchanged and keep rx_valid low.
REQ-020 STOP: in both cases the FSM SHALL return to IDLE on that tick.
REQ-021 rx_valid and frame_err SHALL be registered, high for exactly one clk, on the clk edge that samples the stop bit, and SHALL never be high together.
REQ-022 A low line after STOP (break or back-to-back frame) SHALL be detected as a new start bit on the next tick; there is no minimum idle time.
REQ-023 rx_data SHALL hold its value between frames.
REQ-024 baud_tick held low SHALL freeze all state except the synchronizer.

Reset
REQ-025 On rst=1 the FSM SHALL go to IDLE, and the counter, bit index, shift register, rx_data, rx_valid and frame_err SHALL all go to 0.
REQ-026 On rst=1 the synchronizer flops SHALL go to 1.
REQ-027 Reset mid-frame SHALL abort the frame with no output pulse.

Structure
REQ-028 Package uart_pkg SHALL hold the rx_state_t enum and the SAMPLING_RATE and DATA_BITS defaults shared with uart_baud_gen and the transmitter.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module, uart_sync; uart_rx SHALL NOT instantiate uart_baud_gen (the tick is an input).

Verification
REQ-030 Bench clk 50 MHz with uart_baud_gen at 9600 baud x16; send 0xA5 -> one rx_valid pulse, rx_data=0xA5, frame_err=0.
REQ-031 Send 0x00 then 0xFF back-to-back with 1 stop bit -> two rx_valid pulses, rx_data=0x00 then 0xFF.
REQ-032 Drive rx low for 4 ticks then high -> FSM back in IDLE, no rx_valid and no frame_err.
REQ-033 Send 0x3C after a good 0x11, with the stop bit driven low -> frame_err one pulse, rx_valid=0, rx_data stays 0x11.
REQ-034 Assert rst during data bit 4 of 0x5A, then send 0x5A again -> outputs 0 during reset, then exactly one rx_valid with rx_data=0x5A.
REQ-035 Hold baud_tick=0 for 1000 clk mid-frame, then resume ticks -> the frame completes correctly with no extra pulses.
